fetch_stage: RTL

//  RV32I instruction fetch stage plus IF/ID pipeline register, directly upstream of decode/Extend.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 50 +++++
 rtl/fetch_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset constants and fetch FSM state encodings.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_MISAL = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} holding buffer for a fetch response that lands while IF/ID is stalled.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i || drain_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR_DEFAULT;
      pc_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register: one-outstanding imem handshake, stall skid, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  input  logic        stall_i,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  fetch_state_e state_q, state_d, fresh_state;
  logic [31:0]  pc_q, pc_d, inflight_pc_q, inflight_pc_d, stale_addr_q, stale_addr_d;
  logic         stale_q, stale_d, drop_q, drop_d, misal_q, misal_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d, id_pc_q, id_pc_d, id_pc_plus4_q, id_pc_plus4_d;
  logic         skid_load, skid_drain, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc;
  logic         load_ifid;
  logic [31:0]  load_instr, load_pc;
  logic [31:0]  redir_target;
  logic         redir_misal;

  assign redir_target = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_misal = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_misal = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    stale_d       = stale_q;
    stale_addr_d  = stale_addr_q;
    drop_d        = drop_q;
    misal_d       = misal_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_clear    = 1'b0;
    load_ifid     = 1'b0;
    load_instr    = imem_rdata;
    load_pc       = inflight_pc_q;

    if (redirect_i) begin
      pc_d       = redir_target;
      misal_d    = redir_misal;
      skid_clear = 1'b1;
    end
    // Where to go once no memory transaction is owed: park if the target was misaligned.
    fresh_state = misal_d ? ST_MISAL : ST_REQ;

    case (state_q)
      ST_IDLE: state_d = fresh_state;
      ST_REQ: begin
        if (imem_gnt) begin
          state_d = ST_WAIT;
          if (redirect_i || stale_q) begin
            drop_d  = 1'b1;
            stale_d = 1'b0;
          end else begin
            inflight_pc_d = pc_q;
            pc_d          = pc_plus4(pc_q);
          end
        end else if (redirect_i && !stale_q) begin
          // The request is already on the bus: finish it on the old address, discard its data.
          stale_d      = 1'b1;
          stale_addr_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (redirect_i || drop_q) begin
            state_d = fresh_state;
          end else if (!id_valid_q || !stall_i) begin
            load_ifid = 1'b1;
            state_d   = ST_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          state_d = fresh_state;
        end else if (!stall_i) begin
          state_d    = ST_REQ;
          skid_drain = 1'b1;
          load_ifid  = skid_valid;
          load_instr = skid_instr;
          load_pc    = skid_pc;
        end
      end
      ST_MISAL: if (redirect_i) state_d = fresh_state;
      default:  state_d = ST_IDLE;
    endcase

    if (redirect_i) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (load_ifid) begin
      id_valid_d    = 1'b1;
      id_instr_d    = load_instr;
      id_pc_d       = load_pc;
      id_pc_plus4_d = pc_plus4(load_pc);
    end else if (id_valid_q && !stall_i) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= 32'd0;
      stale_q       <= 1'b0;
      stale_addr_q  <= 32'd0;
      drop_q        <= 1'b0;
      misal_q       <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd4;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      stale_q       <= stale_d;
      stale_addr_q  <= stale_addr_d;
      drop_q        <= drop_d;
      misal_q       <= misal_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc_i    (inflight_pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = stale_q ? stale_addr_q : pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_o  = misal_q;
`endif

endmodule
